mdr_scheduler: RTL and testbench

Shares one multiply/divide/square-root (MDR) core among NUM_REQ requesters. Accepts one operation at a time with round-robin fairness and issues it to the core with a one-cycle start pulse. Waits for core completion or a timeout, then returns a tagged response to the winning requester. Sits between client masters and mdr_wrapper, so the core itself carries no arbitration logic.

---
 rtl/mdr_pkg.sv | 28 ++
 rtl/mdr_rr_arbiter.sv | 35 +++
 rtl/mdr_scheduler.sv | 161 ++++++++++++++++
 tb/tb_mdr_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdr_pkg.sv
// Shared types and default sizing for the MDR scheduler and its arbiter.
package mdr_pkg;

    localparam int MDR_NUM_REQ        = 4;
    localparam int MDR_DATA_WIDTH     = 16;
    localparam int MDR_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        OP_MUL     = 2'b00,
        OP_DIV     = 2'b01,
        OP_SQRT    = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_DIV0    = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_ILLEGAL = 2'b11
    } err_e;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

endpackage

// File: rtl/mdr_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or above the pointer, wrapping.
module mdr_rr_arbiter #(
    parameter int NUM_REQ = mdr_pkg::MDR_NUM_REQ,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IW-1:0]      o_idx,
    output logic               o_any
);

    localparam logic [IW:0] N_L = (IW+1)'(NUM_REQ);

    logic [IW:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_pos = {1'b0, i_ptr} + (IW+1)'(i);
            if (w_pos >= N_L) begin
                w_pos = w_pos - N_L;
            end
            if (!o_any && i_valid[w_pos[IW-1:0]]) begin
                o_any                   = 1'b1;
                o_idx                   = w_pos[IW-1:0];
                o_grant[w_pos[IW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mdr_scheduler.sv
// Arbitrates NUM_REQ clients onto one multiply/divide/sqrt core, one operation in flight,
// with short-circuit error responses and a completion timeout.
module mdr_scheduler
    import mdr_pkg::*;
#(
    parameter int NUM_REQ        = MDR_NUM_REQ,
    parameter int DATA_WIDTH     = MDR_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = MDR_TIMEOUT_CYCLES
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [2*NUM_REQ-1:0]           req_op,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]  req_a,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]  req_b,
    output logic                           rsp_valid,
    output logic [NUM_REQ-1:0]             rsp_id,
    output logic [2*DATA_WIDTH-1:0]        rsp_result,
    output logic [DATA_WIDTH-1:0]          rsp_remainder,
    output logic [1:0]                     rsp_err,
    output logic                           core_start,
    output logic [1:0]                     core_op,
    output logic [DATA_WIDTH-1:0]          core_a,
    output logic [DATA_WIDTH-1:0]          core_b,
    input  logic                           core_done,
    input  logic [2*DATA_WIDTH-1:0]        core_result,
    input  logic [DATA_WIDTH-1:0]          core_remainder,
    input  logic                           core_err
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [IW:0] N_L = (IW+1)'(NUM_REQ);

    state_t                  r_state;
    logic [IW-1:0]           r_ptr;
    logic [NUM_REQ-1:0]      r_id;
    op_e                     r_op;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [CW-1:0]           r_cnt;
    logic [2*DATA_WIDTH-1:0] r_result;
    logic [DATA_WIDTH-1:0]   r_rem;
    err_e                    r_err;

    op_e                     w_op [NUM_REQ];
    logic [DATA_WIDTH-1:0]   w_a  [NUM_REQ];
    logic [DATA_WIDTH-1:0]   w_b  [NUM_REQ];
    logic [NUM_REQ-1:0]      w_grant;
    logic [IW-1:0]           w_grant_idx;
    logic                    w_any;
    op_e                     w_sel_op;
    logic [DATA_WIDTH-1:0]   w_sel_a;
    logic [DATA_WIDTH-1:0]   w_sel_b;
    logic [IW:0]             w_inc;
    logic [IW-1:0]           w_ptr_next;
    logic                    w_timeout;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_op[gi] = op_e'(req_op[2*gi +: 2]);
            assign w_a[gi]  = req_a[DATA_WIDTH*gi +: DATA_WIDTH];
            assign w_b[gi]  = req_b[DATA_WIDTH*gi +: DATA_WIDTH];
        end
    endgenerate

    mdr_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_arb (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx),
        .o_any   (w_any)
    );

    assign w_sel_op   = w_op[w_grant_idx];
    assign w_sel_a    = w_a[w_grant_idx];
    assign w_sel_b    = w_b[w_grant_idx];
    assign w_inc      = {1'b0, w_grant_idx} + (IW+1)'(1);
    assign w_ptr_next = (w_inc == N_L) ? '0 : w_inc[IW-1:0];
    // Counter starts at 0 on the first WAIT cycle, so this fires on the last allowed one.
    assign w_timeout  = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    assign req_ready     = (r_state == ST_IDLE) ? w_grant : '0;
    assign core_start    = (r_state == ST_ISSUE);
    assign rsp_valid     = (r_state == ST_RESP);
    assign rsp_id        = (r_state == ST_RESP) ? r_id : '0;
    assign core_op       = r_op;
    assign core_a        = r_a;
    assign core_b        = r_b;
    assign rsp_result    = r_result;
    assign rsp_remainder = r_rem;
    assign rsp_err       = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_id     <= '0;
            r_op     <= OP_MUL;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_rem    <= '0;
            r_err    <= ERR_OK;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_op  <= w_sel_op;
                        r_a   <= w_sel_a;
                        r_b   <= w_sel_b;
                        r_id  <= w_grant;
                        r_ptr <= w_ptr_next;
                        if (w_sel_op == OP_ILLEGAL) begin
                            r_state  <= ST_RESP;
                            r_result <= '1;
                            r_rem    <= '0;
                            r_err    <= ERR_ILLEGAL;
                        end else if (w_sel_op == OP_DIV && w_sel_b == '0) begin
                            r_state  <= ST_RESP;
                            r_result <= '1;
                            r_rem    <= '0;
                            r_err    <= ERR_DIV0;
                        end else begin
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_done) begin
                        r_result <= core_result;
                        r_rem    <= (r_op == OP_DIV) ? core_remainder : '0;
                        r_err    <= core_err ? ERR_DIV0 : ERR_OK;
                        r_state  <= ST_RESP;
                    end else if (w_timeout) begin
                        r_result <= '0;
                        r_rem    <= '0;
                        r_err    <= ERR_TIMEOUT;
                        r_state  <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdr_scheduler.sv
// Self-checking bench for mdr_scheduler: vector table, fairness, timeout and reset sequences.
module tb_mdr_scheduler;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int TO = 255;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [2*N-1:0]    req_op;
    logic [DW*N-1:0]   req_a;
    logic [DW*N-1:0]   req_b;
    logic              rsp_valid;
    logic [N-1:0]      rsp_id;
    logic [2*DW-1:0]   rsp_result;
    logic [DW-1:0]     rsp_remainder;
    logic [1:0]        rsp_err;
    logic              core_start;
    logic [1:0]        core_op;
    logic [DW-1:0]     core_a;
    logic [DW-1:0]     core_b;
    logic              core_done = 1'b0;
    logic [2*DW-1:0]   core_result = '0;
    logic [DW-1:0]     core_remainder = '0;
    logic              core_err = 1'b0;

    mdr_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_a          (req_a),
        .req_b          (req_b),
        .rsp_valid      (rsp_valid),
        .rsp_id         (rsp_id),
        .rsp_result     (rsp_result),
        .rsp_remainder  (rsp_remainder),
        .rsp_err        (rsp_err),
        .core_start     (core_start),
        .core_op        (core_op),
        .core_a         (core_a),
        .core_b         (core_b),
        .core_done      (core_done),
        .core_result    (core_result),
        .core_remainder (core_remainder),
        .core_err       (core_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0]    id;
        logic [2*DW-1:0] result;
        logic [DW-1:0]   rem;
        logic [1:0]      err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   rsp_count = 0;
    int   last_rsp_cyc = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor and one-hot ready watch
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (req_ready != '0) check("req_ready_onehot", 96'($countones(req_ready)), 96'd1);
            if (rsp_valid) begin
                rsp_count++;
                last_rsp_cyc = cyc;
                $display("rsp cyc=%0d id=%b result=%0h rem=%0h err=%0d",
                         cyc, rsp_id, rsp_result, rsp_remainder, rsp_err);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got id=%b expected no response", rsp_id);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", 96'(rsp_id), 96'(e.id));
                    check("rsp_result", 96'(rsp_result), 96'(e.result));
                    check("rsp_remainder", 96'(rsp_remainder), 96'(e.rem));
                    check("rsp_err", 96'(rsp_err), 96'(e.err));
                end
            end
        end
    end

    // Behavioural core: done pulse core_delay cycles after start, math from the live core inputs
    logic          core_mute = 1'b0;
    logic          cerr_knob = 1'b0;
    logic          inject_done = 1'b0;
    int            core_delay = 1;
    int            pend = 0;
    int            n_starts = 0;
    logic [1:0]    seen_op = '0;
    logic [DW-1:0] seen_a = '0;
    logic [DW-1:0] seen_b = '0;

    function automatic logic [DW-1:0] isqrt(input logic [DW-1:0] v);
        int r = 0;
        while ((r + 1) * (r + 1) <= int'(v)) r++;
        return DW'(r);
    endfunction

    always begin
        @(posedge clk);
        #1;
        core_done = 1'b0;
        core_err  = 1'b0;
        if (rst) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    core_done = 1'b1;
                    core_err  = cerr_knob;
                    core_remainder = '0;
                    case (core_op)
                        2'b00: core_result = 32'(core_a) * 32'(core_b);
                        2'b01: begin
                            core_result    = (core_b != 0) ? 32'(core_a / core_b) : '1;
                            core_remainder = (core_b != 0) ? core_a % core_b : '0;
                        end
                        2'b10: core_result = 32'(isqrt(core_a));
                        default: core_result = '0;
                    endcase
                end
            end
            if (inject_done) begin
                core_done   = 1'b1;
                inject_done = 1'b0;
            end
            if (core_start) begin
                n_starts++;
                seen_op = core_op;
                seen_a  = core_a;
                seen_b  = core_b;
                if (!core_mute) pend = core_delay;
            end
        end
    end

    task automatic issue(input int id, input logic [1:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input bit push, input exp_t e, output int t_hs);
        @(posedge clk);
        #1;
        req_op    = 8'($urandom);
        req_a     = {$urandom, $urandom};
        req_b     = {$urandom, $urandom};
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_op[2*id +: 2]  = op;
        req_a[DW*id +: DW] = a;
        req_b[DW*id +: DW] = b;
        t_hs = -1;
        for (int k = 0; k < 100 && t_hs < 0; k++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                t_hs = cyc;
                if (push) sb.push_back(e);
            end
        end
        if (t_hs < 0) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: got no req_ready for id %0d expected a grant", id);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        req_a     = {$urandom, $urandom};
        req_b     = {$urandom, $urandom};
    endtask

    task automatic wait_idle(input int bound);
        for (int k = 0; k < bound && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: got %0d responses still pending expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        int              id;
        logic [1:0]      op;
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;
        int              dly;
        logic            cerr;
        logic [2*DW-1:0] res;
        logic [DW-1:0]   rem;
        logic [1:0]      err;
        int              lat;
        int              nstart;
    } vec_t;

    vec_t vecs[9];

    initial begin
        exp_t e;
        int   t_hs;
        int   s0;
        int   n0;
        int   order[$];
        int   gidx;

        vecs[0] = '{0, 2'b00, 16'd300,   16'd200,   3, 1'b0, 32'd60000,      16'd0, 2'b00, 5, 1};
        vecs[1] = '{2, 2'b01, 16'd17,    16'd0,     1, 1'b0, 32'hFFFF_FFFF,  16'd0, 2'b01, 1, 0};
        vecs[2] = '{1, 2'b11, 16'd5,     16'd6,     1, 1'b0, 32'hFFFF_FFFF,  16'd0, 2'b11, 1, 0};
        vecs[3] = '{3, 2'b01, 16'd17,    16'd5,     2, 1'b0, 32'd3,          16'd2, 2'b00, 4, 1};
        vecs[4] = '{0, 2'b10, 16'd144,   16'd99,    1, 1'b0, 32'd12,         16'd0, 2'b00, 3, 1};
        vecs[5] = '{2, 2'b00, 16'hFFFF,  16'hFFFF,  4, 1'b0, 32'hFFFE_0001,  16'd0, 2'b00, 6, 1};
        vecs[6] = '{1, 2'b01, 16'd100,   16'd7,     1, 1'b1, 32'd14,         16'd2, 2'b01, 3, 1};
        vecs[7] = '{3, 2'b10, 16'hFFFF,  16'd0,     2, 1'b0, 32'd255,        16'd0, 2'b00, 4, 1};
        vecs[8] = '{0, 2'b01, 16'd5,     16'd9,     1, 1'b0, 32'd0,          16'd5, 2'b00, 3, 1};

        rst = 1'b1;
        req_valid = '0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", 96'({req_ready, rsp_valid, rsp_id, rsp_err, core_start, core_op}), 96'd0);
        check("reset_data", {rsp_result, rsp_remainder, core_a, core_b}, 96'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            core_delay = vecs[i].dly;
            cerr_knob  = vecs[i].cerr;
            s0 = n_starts;
            e.id = '0;
            e.id[vecs[i].id] = 1'b1;
            e.result = vecs[i].res;
            e.rem    = vecs[i].rem;
            e.err    = vecs[i].err;
            issue(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, e, t_hs);
            wait_idle(400);
            check("latency", 96'(last_rsp_cyc - t_hs), 96'(vecs[i].lat));
            check("start_count", 96'(n_starts - s0), 96'(vecs[i].nstart));
            if (vecs[i].nstart != 0)
                check("core_args", 96'({seen_op, seen_a, seen_b}), 96'({vecs[i].op, vecs[i].a, vecs[i].b}));
        end
        cerr_knob = 1'b0;

        // Fairness: all requesters valid continuously from a freshly reset pointer
        pulse_reset();
        core_delay = 1;
        for (int r = 0; r < N; r++) begin
            req_op[2*r +: 2]  = 2'b00;
            req_a[DW*r +: DW] = 16'd2;
            req_b[DW*r +: DW] = 16'd3;
        end
        req_valid = '1;
        for (int k = 0; k < 300 && order.size() < 5; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                gidx = 0;
                for (int r = 0; r < N; r++) if (req_ready[r]) gidx = r;
                order.push_back(gidx);
                e.id = req_ready;
                e.result = 32'd6;
                e.rem = '0;
                e.err = 2'b00;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        check("grant_count", 96'(order.size()), 96'd5);
        foreach (order[i]) check("grant_order", 96'(order[i]), 96'(i % N));
        wait_idle(400);

        // Core never answers: timeout, then a stale done must be ignored
        core_mute = 1'b1;
        s0 = n_starts;
        e.id = 4'b0010;
        e.result = '0;
        e.rem = '0;
        e.err = 2'b10;
        issue(1, 2'b00, 16'd2, 16'd3, 1'b1, e, t_hs);
        wait_idle(600);
        check("timeout_latency", 96'(last_rsp_cyc - t_hs), 96'(TO + 2));
        check("timeout_starts", 96'(n_starts - s0), 96'd1);
        n0 = rsp_count;
        repeat (9) @(posedge clk);
        #1;
        inject_done = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("late_done_ignored", 96'(rsp_count), 96'(n0));

        // Reset while waiting on the core aborts the operation silently
        issue(2, 2'b00, 16'd7, 16'd8, 1'b0, e, t_hs);
        repeat (4) @(posedge clk);
        #1;
        n0 = rsp_count;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_ctrl", 96'({req_ready, rsp_valid, rsp_id, rsp_err, core_start, core_op}), 96'd0);
        check("midrst_data", {rsp_result, rsp_remainder, core_a, core_b}, 96'd0);
        repeat (5) @(posedge clk);
        #1;
        check("midrst_no_rsp", 96'(rsp_count), 96'(n0));
        core_mute = 1'b0;
        core_delay = 2;
        e.id = 4'b0100;
        e.result = 32'd12;
        e.rem = '0;
        e.err = 2'b00;
        issue(2, 2'b10, 16'd144, 16'd0, 1'b1, e, t_hs);
        wait_idle(400);
        check("post_rst_latency", 96'(last_rsp_cyc - t_hs), 96'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
